// File: rtl/counter_sched_if.sv
// Request/grant bundle between client blocks and the shared-counter scheduler.
interface counter_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] len;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic [WIDTH-1:0]         count;
    logic [NUM_REQ-1:0]       done;

    // Client side: raises requests, watches grant/count/done.
    modport master (
        output req, len,
        input  gnt, busy, count, done
    );

    // Scheduler side.
    modport slave (
        input  req, len,
        output gnt, busy, count, done
    );
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one WIDTH-bit up-counter among NUM_REQ requesters.
// Optional: define COUNTER_SCHED_ABORT_EN to let the owner abort by dropping req.
module counter_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input logic             clk,
    input logic             reset,
    counter_sched_if.slave  bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nx;
    logic [PW-1:0]      ptr, ptr_nx;
    logic [WIDTH-1:0]   len_q, len_nx;
    logic [WIDTH-1:0]   count, count_nx;
    logic [NUM_REQ-1:0] gnt, gnt_nx;
    logic [NUM_REQ-1:0] done, done_nx;
    logic [PW-1:0]      pick;
    logic               found;

    // First set request after ptr, wrapping; ptr holds the last owner.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        len_nx   = len_q;
        count_nx = count;
        gnt_nx   = gnt;
        done_nx  = '0;
        case (state)
            IDLE: begin
                count_nx = '0;
                gnt_nx   = '0;
                if (found) begin
                    state_nx     = RUN;
                    gnt_nx[pick] = 1'b1;
                    len_nx       = bus.len[int'(pick)*WIDTH +: WIDTH];
                    ptr_nx       = pick;
                end
            end
            RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
                if (!bus.req[ptr]) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    count_nx = '0;
                end else
`endif
                if (count == len_q) begin
                    state_nx     = IDLE;
                    gnt_nx       = '0;
                    count_nx     = '0;
                    done_nx[ptr] = 1'b1;
                end else begin
                    count_nx = count + WIDTH'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset mid-run drops the interval silently and restores req[0] priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= PW'(NUM_REQ - 1);
            len_q <= '0;
            count <= '0;
            gnt   <= '0;
            done  <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            len_q <= len_nx;
            count <= count_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
        end
    end

    assign bus.gnt   = gnt;
    assign bus.busy  = |gnt;
    assign bus.count = count;
    assign bus.done  = done;
endmodule
